// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder_ctrl
// Description : WIDTH-bit adder that reuses one 4-bit ripple slice over the
//               operand nibbles, LSB first, behind a start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_width_bad
            $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    logic [1:0]       state_q,   state_d;
    logic [WIDTH-1:0] a_q,       a_d;
    logic [WIDTH-1:0] b_q,       b_d;
    logic [WIDTH-1:0] partial_q, partial_d;
    logic [WIDTH-1:0] sum_q,     sum_d;
    logic             carry_q,   carry_d;
    logic             cout_q,    cout_d;
    logic [IDXW-1:0]  idx_q,     idx_d;

    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [3:0]       w_s;
    logic [4:0]       w_chain;

    // Shared 4-bit slice: operand nibble select followed by a full-adder ripple.
    always_comb begin
        w_a_nib = '0;
        w_b_nib = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDXW'(i)) begin
                w_a_nib = a_q[i*4 +: 4];
                w_b_nib = b_q[i*4 +: 4];
            end
        end
        w_s        = '0;
        w_chain    = '0;
        w_chain[0] = carry_q;
        for (int i = 0; i < 4; i++) begin
            w_s[i]       = w_a_nib[i] ^ w_b_nib[i] ^ w_chain[i];
            w_chain[i+1] = (w_a_nib[i] & w_b_nib[i]) |
                           (w_chain[i] & (w_a_nib[i] ^ w_b_nib[i]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            partial_q <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            partial_q <= partial_d;
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            cout_q    <= cout_d;
            idx_q     <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        partial_d = partial_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        idx_d     = idx_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                // DONE accepts a new request directly for back-to-back operation.
                if (start) begin
                    a_d       = a;
                    b_d       = b;
                    carry_d   = cin;
                    idx_d     = '0;
                    partial_d = '0;
                    state_d   = S_RUN;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        partial_d[i*4 +: 4] = w_s;
                    end
                end
                carry_d = w_chain[4];
                if (idx_q == IDXW'(NIBBLES - 1)) begin
                    sum_d   = partial_d;
                    cout_d  = w_chain[4];
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IDXW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_adder_ctrl
// Description : Directed scoreboard bench for nibble_serial_adder_ctrl (WIDTH=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder_ctrl;

    localparam int WIDTH   = 16;
    localparam int NIBBLES = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int checks = 0;
    int errors = 0;
    int done_pulses = 0;
    int n_results = 0;

    logic [WIDTH:0]   sb[$];
    logic [WIDTH-1:0] last_sum = '0;
    logic             last_cout = 1'b0;

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done === 1'b1) done_pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic tc);
        a     = ta;
        b     = tb_;
        cin   = tc;
        start = 1'b1;
        sb.push_back({1'b0, ta} + {1'b0, tb_} + {{WIDTH{1'b0}}, tc});
    endtask

    // Waits for done, checking busy and that sum holds its previous value meanwhile.
    task automatic wait_done(input string tag);
        int lat;
        lat = 0;
        while (lat < 20) begin
            tick();
            start = 1'b0;
            lat++;
            if (done === 1'b1) break;
            chk({tag, "_busy_run"}, {31'b0, busy}, 32'd1);
            chk({tag, "_sum_hold"}, {15'b0, cout, sum}, {15'b0, last_cout, last_sum});
        end
        chk({tag, "_done_seen"}, {31'b0, done}, 32'd1);
        chk({tag, "_latency"}, lat, NIBBLES + 1);
        chk({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic check_result(input string tag);
        logic [WIDTH:0] exp;
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        chk({tag, "_sum"},  {16'b0, sum}, {16'b0, exp[WIDTH-1:0]});
        chk({tag, "_cout"}, {31'b0, cout}, {31'b0, exp[WIDTH]});
        last_sum  = exp[WIDTH-1:0];
        last_cout = exp[WIDTH];
        n_results++;
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_sum",  {16'b0, sum}, 32'd0);
        chk("rst_cout", {31'b0, cout}, 32'd0);
        rst = 1'b0;
        tick();

        // Full carry propagation across all nibbles
        issue(16'hFFFF, 16'h0001, 1'b0);
        wait_done("t1");
        check_result("t1");
        tick();
        chk("t1_done_fall", {31'b0, done}, 32'd0);

        // Carry-in path, then hold across idle cycles
        issue(16'h1234, 16'h4321, 1'b1);
        wait_done("t2");
        check_result("t2");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_idle_done", {31'b0, done}, 32'd0);
            chk("t2_idle_sum",  {16'b0, sum}, 32'h5556);
        end

        // start and operand churn while RUN must be ignored
        issue(16'h1234, 16'h4321, 1'b1);
        tick();
        chk("t3_busy0", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            a = 16'hAAAA ^ WIDTH'(i * 16'h0111);
            b = 16'h5555 ^ WIDTH'(i * 16'h1010);
            cin = ~cin;
            start = 1'b1;
            tick();
            chk("t3_busy_run", {31'b0, busy}, 32'd1);
            chk("t3_no_done", {31'b0, done}, 32'd0);
        end
        a = 16'hAAAA;
        b = 16'h5555;
        tick();
        start = 1'b0;
        chk("t3_done", {31'b0, done}, 32'd1);
        check_result("t3");
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_no_second_done", {30'b0, busy, done}, 32'd0);
        end

        // Back-to-back: start held through DONE
        issue(16'h0001, 16'h0002, 1'b0);
        wait_done("t4a");
        check_result("t4a");
        issue(16'h8000, 16'h8000, 1'b0);
        wait_done("t4b");
        check_result("t4b");
        tick();
        chk("t4_done_fall", {31'b0, done}, 32'd0);

        // A few random operands
        for (int i = 0; i < 4; i++) begin
            issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            wait_done("rnd");
            check_result("rnd");
            tick();
        end

        // Asynchronous reset two cycles into RUN aborts the operation
        issue(16'h1111, 16'h1111, 1'b0);
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("t5_busy_pre", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_rst_busy", {31'b0, busy}, 32'd0);
        chk("t5_rst_done", {31'b0, done}, 32'd0);
        chk("t5_rst_sum",  {16'b0, sum}, 32'd0);
        chk("t5_rst_cout", {31'b0, cout}, 32'd0);
        void'(sb.pop_back());
        last_sum  = '0;
        last_cout = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t5_idle", {30'b0, busy, done}, 32'd0);
        end
        issue(16'h00FF, 16'h0F01, 1'b0);
        wait_done("t5");
        check_result("t5");
        tick();

        chk("done_pulse_count", done_pulses, n_results);
        chk("sb_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
